// File: rtl/vec_fu_issue.sv
// Issue side of the vector FU start/done handshake: registers operands, holds start,
// captures the result or aborts on timeout, and counts overflowing completions.
module vec_fu_issue #(
    parameter int VW      = 256,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ReqValid,
    output logic          ReqReady,
    input  logic [VW-1:0] ReqA,
    input  logic [VW-1:0] ReqB,
    output logic [VW-1:0] FuA,
    output logic [VW-1:0] FuB,
    output logic          FuStart,
    input  logic          FuDone,
    input  logic [VW-1:0] FuResult,
    input  logic          FuOverflw,
    output logic          RspValid,
    input  logic          RspReady,
    output logic [VW-1:0] RspData,
    output logic          RspOverflw,
    output logic          RspTimeout,
    output logic [15:0]   OvCount,
    input  logic          OvClr
);

    // IDLE: ready for request | ISSUE: FuStart held, waiting done | RESP: response held
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          done_ov;

    // The counter value after this edge would equal TIMEOUT: FuStart has been high TIMEOUT cycles.
    assign tmo_hit  = (tmo_cnt + TW'(1)) == TW'(TIMEOUT);
    assign done_ov  = (state == ISSUE) && FuDone && FuOverflw;

    assign ReqReady = (state == IDLE);
    assign FuStart  = (state == ISSUE);
    assign RspValid = (state == RESP);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ReqValid) state_nx = ISSUE;
            ISSUE:   if (FuDone || tmo_hit) state_nx = RESP;
            RESP:    if (RspReady) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            FuA        <= '0;
            FuB        <= '0;
            tmo_cnt    <= '0;
            RspData    <= '0;
            RspOverflw <= 1'b0;
            RspTimeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        FuA     <= ReqA;
                        FuB     <= ReqB;
                        tmo_cnt <= '0;
                    end
                end
                ISSUE: begin
                    // Done takes priority over a timeout landing on the same edge.
                    if (FuDone) begin
                        RspData    <= FuResult;
                        RspOverflw <= FuOverflw;
                        RspTimeout <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                        if (tmo_hit) begin
                            RspData    <= '0;
                            RspOverflw <= 1'b0;
                            RspTimeout <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || OvClr)
            OvCount <= '0;
        else if (done_ov && (OvCount != 16'hFFFF))
            OvCount <= OvCount + 16'd1;
    end

endmodule
